// File: rtl/exc_ctrl_if.sv
// -----------------------------------------------------------------------------
// exc_ctrl_pkg / exc_ctrl_if
//
// The package holds the types that are shared by the exception controller, CP0
// and the testbench:
//   exception_t : {valid, code, pc, badvaddr, in_delay_slot}, the record that
//                 CP0 commits.
//   rd_state_t  : the state of the fetch-redirect register (debug view).
//
// The interface carries the fetch-redirect handshake.
//   redirect_valid  master -> slave   a redirect target is pending
//   redirect_pc     master -> slave   redirect target, stable while valid
//   redirect_ready  slave  -> master  fetch accepts the redirect
//
// Handshake: a transfer happens on a rising clock edge when both
// redirect_valid and redirect_ready are 1. Once valid is raised, it and
// redirect_pc stay unchanged until that edge. Ready may be high before valid
// and may depend on valid. Valid never depends on ready in the same cycle.
// -----------------------------------------------------------------------------
package exc_ctrl_pkg;

    typedef struct packed {
        logic        valid;
        logic [4:0]  code;
        logic [31:0] pc;
        logic [31:0] badvaddr;
        logic        in_delay_slot;
    } exception_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_PEND = 1'b1
    } rd_state_t;

endpackage

interface exc_ctrl_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl
//
// Exception controller between the memory/commit stage and CP0. It
// synchronises the external interrupt lines and latches the count/compare
// timer interrupt. Each cycle it picks the single highest-priority exception
// for the retiring instruction, or the ERET. It raises the pipeline flush
// combinationally and loads a registered fetch redirect: the exception vector,
// or EPC for ERET.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   ext_int[5:0]            asynchronous level-sensitive interrupt lines
//   commit_*                commit slot: valid/stall, pc, delay slot, fault
//                           flags, data address, eret
//   cp0_*                   Status IE/EXL/IM, Cause.IP[1:0], Count, Compare,
//                           Compare write strobe, EPC
//   exception               exception record to CP0 (exception_t)
//   eret                    ERET retiring, to CP0
//   flush                   squash all younger stages
//   hw_ip[5:0]              synchronised pending hardware interrupts
//   rdr                     fetch redirect handshake (exc_ctrl_if.master)
//   dbg_redirect_state      state of the redirect register
// -----------------------------------------------------------------------------
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [5:0]  ext_int,

    input  logic        commit_valid,
    input  logic        commit_stall,
    input  logic [31:0] commit_pc,
    input  logic        commit_in_delay_slot,
    input  logic        commit_adel_if,
    input  logic        commit_ri,
    input  logic        commit_ov,
    input  logic        commit_sys,
    input  logic        commit_bp,
    input  logic        commit_adel_ld,
    input  logic        commit_ades,
    input  logic [31:0] commit_mem_addr,
    input  logic        commit_eret,

    input  logic        cp0_status_ie,
    input  logic        cp0_status_exl,
    input  logic [7:0]  cp0_status_im,
    input  logic [1:0]  cp0_cause_ip_sw,
    input  logic [31:0] cp0_count,
    input  logic [31:0] cp0_compare,
    input  logic        cp0_compare_we,
    input  logic [31:0] cp0_epc,

    output exception_t  exception,
    output logic        eret,
    output logic        flush,
    output logic [5:0]  hw_ip,

    exc_ctrl_if.master  rdr,
    output rd_state_t   dbg_redirect_state
);

    // ---------------------------------------------------------------- sync
    logic [5:0] sync_q [SYNC_STAGES];
    logic [5:0] int_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= ext_int;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign int_sync = sync_q[SYNC_STAGES-1];

    // --------------------------------------------------------------- timer
    // A Compare write acknowledges the timer, so it also wins over a match
    // in the same cycle.
    logic ti;

    always_ff @(posedge clk) begin
        if (reset)                          ti <= 1'b0;
        else if (cp0_compare_we)            ti <= 1'b0;
        else if (cp0_count == cp0_compare)  ti <= 1'b1;
    end

    assign hw_ip = {int_sync[5] | ti, int_sync[4:0]};

    // ----------------------------------------------------- request / retire
    logic      int_req;
    logic      retire;
    rd_state_t rd_state_q;
    rd_state_t rd_state_d;
    logic [31:0] redirect_pc_q;
    logic [31:0] redirect_pc_d;
    logic      redirect_busy;

    assign int_req = cp0_status_ie & ~cp0_status_exl &
                     (|({hw_ip, cp0_cause_ip_sw} & cp0_status_im));

    assign redirect_busy = (rd_state_q == RD_PEND);

    // A pending redirect blocks retirement. This keeps a second flush from
    // overwriting a target that fetch has not taken yet.
    assign retire = ~reset & commit_valid & ~commit_stall & ~redirect_busy;

    // ------------------------------------------------------------ priority
    logic        exc_hit;
    logic [4:0]  exc_code;
    logic [31:0] exc_bad;
    logic        exc_valid;

    always_comb begin
        exc_hit  = 1'b1;
        exc_code = 5'h00;
        exc_bad  = '0;
        if (int_req) begin
            exc_code = 5'h00;
        end else if (commit_adel_if) begin
            exc_code = 5'h04;
            exc_bad  = commit_pc;
        end else if (commit_ri) begin
            exc_code = 5'h0A;
        end else if (commit_ov) begin
            exc_code = 5'h0C;
        end else if (commit_sys) begin
            exc_code = 5'h08;
        end else if (commit_bp) begin
            exc_code = 5'h09;
        end else if (commit_adel_ld) begin
            exc_code = 5'h04;
            exc_bad  = commit_mem_addr;
        end else if (commit_ades) begin
            exc_code = 5'h05;
            exc_bad  = commit_mem_addr;
        end else begin
            exc_hit  = 1'b0;
        end
    end

    assign exc_valid = retire & exc_hit;

    always_comb begin
        exception.valid         = exc_valid;
        exception.code          = exc_valid ? exc_code : 5'h00;
        exception.pc            = commit_pc;
        exception.badvaddr      = exc_valid ? exc_bad : 32'h0;
        exception.in_delay_slot = commit_in_delay_slot;
    end

    // An exception or interrupt on the same instruction pre-empts ERET.
    assign eret  = retire & commit_eret & ~exc_valid;
    assign flush = exc_valid | eret;

    // ------------------------------------------------------ redirect FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q    <= RD_IDLE;
            redirect_pc_q <= '0;
        end else begin
            rd_state_q    <= rd_state_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        rd_state_d    = rd_state_q;
        redirect_pc_d = redirect_pc_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (flush) begin
                    rd_state_d = RD_PEND;
                    // EPC is sampled before CP0 updates it on this edge.
                    redirect_pc_d = exc_valid ? EXC_VECTOR : cp0_epc;
                end
            end
            RD_PEND: begin
                if (rdr.redirect_ready) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        rdr.redirect_valid = redirect_busy;
        rdr.redirect_pc    = redirect_pc_q;
        dbg_redirect_state = rd_state_q;
    end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception controller between the memory/commit stage and the CP0 register file. It samples and synchronises the hardware interrupt lines and latches the count/compare timer interrupt. Each cycle it picks the single highest-priority exception for the committing instruction and builds the exception record and eret pulse that CP0 consumes. It also issues the pipeline flush and the registered fetch redirect (exception vector or EPC).

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC0_0380, fetch target for every exception and interrupt.
- SYNC_STAGES, 2, synchroniser depth on ext_int (legal 2..3).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- ext_int  in  6  asynchronous hardware interrupt lines, level-sensitive, active-high.
- commit_valid  in  1  an instruction occupies the commit slot.
- commit_stall  in  1  commit slot is stalled this cycle; nothing retires.
- commit_pc  in  32  PC of the committing instruction.
- commit_in_delay_slot  in  1  instruction is in a branch delay slot.
- commit_adel_if, commit_ri, commit_ov, commit_sys, commit_bp  in  1 each  fetch misalign, reserved instruction, overflow, syscall, break.
- commit_adel_ld, commit_ades  in  1 each  load / store address error.
- commit_mem_addr  in  32  data address for load/store errors.
- commit_eret  in  1  instruction is ERET.
- cp0_status_ie, cp0_status_exl  in  1 each  current CP0 Status bits.
- cp0_status_im  in  8  Status.IM.
- cp0_cause_ip_sw  in  2  Cause.IP[1:0] (software interrupts).
- cp0_count, cp0_compare  in  32 each  current CP0 Count / Compare.
- cp0_compare_we  in  1  CP0 write to Compare (reg 11) this cycle.
- cp0_epc  in  32  current EPC.
- exception  out  exception_t  {valid, code, pc, badvaddr, in_delay_slot} to CP0.
- eret  out  1  ERET retiring, to CP0.
- flush  out  1  squash all younger pipeline stages.
- hw_ip  out  6  synchronised pending hardware interrupts (Cause.IP[7:2] view); bit 5 ORs in the timer.
- redirect_valid  out  1  fetch redirect pending.
- redirect_pc  out  32  fetch redirect target.
- redirect_ready  in  1  fetch accepted the redirect.

## Operation
- Synchroniser: each ext_int bit passes through SYNC_STAGES flops. int_sync is the last stage.
- Timer latch ti:
  - Set on the cycle when cp0_count == cp0_compare.
  - Cleared on cp0_compare_we; clear wins over a simultaneous set.
  - Sticky otherwise.
- hw_ip = {int_sync[5] | ti, int_sync[4:0]}.
- Interrupt request: int_req = cp0_status_ie & ~cp0_status_exl & |({hw_ip, cp0_cause_ip_sw} & cp0_status_im).
- retire = commit_valid & ~commit_stall & ~redirect_valid. Nothing is taken unless retire is 1.
- Priority, highest first; codes in hex:
  - Int (00) when int_req.
  - AdEL (04) fetch, badvaddr = commit_pc.
  - RI (0A).
  - Ov (0C), then Sys (08), then Bp (09).
  - AdEL (04) load, badvaddr = commit_mem_addr.
  - AdES (05), badvaddr = commit_mem_addr.
- exception.valid = retire & (any flag | int_req). Fields pc and in_delay_slot copy the commit inputs. badvaddr is 0 for codes without an address.
- eret = retire & commit_eret & ~exception.valid. An exception or interrupt pre-empts ERET.
- flush = exception.valid | eret. Combinational, same cycle as retire.
- Redirect register:
  - Loaded on flush: redirect_pc = EXC_VECTOR for an exception, cp0_epc for eret (EPC sampled that cycle, before CP0's update).
  - redirect_valid is held until the cycle redirect_ready is 1, then cleared.
  - A new flush cannot occur while redirect_valid is 1, because retire is gated.

## Timing
- Reset: synchroniser flops 0, ti 0, redirect_valid 0, redirect_pc 0. exception.valid, eret and flush are 0 in the reset cycle (retire forced 0 while reset).
- ext_int to hw_ip: SYNC_STAGES cycles. Compare match to hw_ip[5]: 1 cycle.
- exception, eret, flush: 0-cycle, combinational from commit inputs. CP0 commits on the same edge.
- redirect_valid: rises the cycle after flush. The minimum redirect pulse is 1 cycle (ready already high).
- Interrupt with commit slot empty or stalled: not taken; it is taken at the first retire cycle while still enabled.
- Interrupt masked by EXL set in the same cycle as a synchronous fault: the fault is taken, code is not 00.
- Reset mid-redirect: redirect_valid drops on the reset edge. No pending exception survives reset.

## Test plan
- Overflow at pc 0x8000_1000, not delay slot, IE=0 -> exception.valid=1, code 0C, flush=1. Next cycle redirect_valid=1, redirect_pc=0xBFC0_0380, held 3 cycles with redirect_ready=0, cleared after ready.
- adel_if and ri set together at pc 0x8000_0002 -> code 04, badvaddr 0x8000_0002. Store with ades, mem_addr 0x1000_0003 -> code 05, badvaddr 0x1000_0003.
- IE=1, EXL=0, IM=0x04, ext_int[0] rises -> hw_ip[0]=1 after 2 cycles. With commit_stall=1 no exception; on the first unstalled valid commit, code 00. With IM=0 it is never taken.
- Count==Compare -> hw_ip[5]=1 the next cycle and stays. Compare write the same cycle as a match -> ti remains 0.
- ERET with EPC 0x8000_2000 -> eret=1, flush=1, redirect_pc=0x8000_2000. ERET with a pending enabled interrupt -> code 00, eret=0.
- Reset asserted while redirect_valid=1 -> redirect_valid=0, exception.valid=0, hw_ip=0 the cycle after.
